// File: rtl/assist_level_sel.sv
// Assist level selector: turns push-button activity into a rider-selected
// assist level. A short press steps the level up (wrapping to 0), a long press
// forces assist off, and a lockout window after each accepted press masks
// contact bounce. All outputs are registered.
module assist_level_sel #(
    parameter int LONG_CYC    = 25000000,
    parameter int LOCKOUT_CYC = 1000000,
    parameter int NUM_LVL     = 4,
    parameter int RST_LVL     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pb_lvl,
    input  logic                       released,
    output logic [$clog2(NUM_LVL)-1:0] assist_lvl,
    output logic [NUM_LVL-1:0]         led,
    output logic                       lvl_chg,
    output logic                       long_press
);

    localparam int LW     = $clog2(NUM_LVL);
    localparam int LONG_W = $clog2(LONG_CYC);
    localparam int LOCK_W = $clog2(LOCKOUT_CYC);
    localparam int CW     = ((LONG_W > LOCK_W) ? LONG_W : LOCK_W) + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    localparam logic [LW-1:0] TOP_LVL   = LW'(NUM_LVL - 1);
    localparam logic [LW-1:0] ZERO_LVL  = {LW{1'b0}};
    localparam logic [LW-1:0] INIT_LVL  = LW'(RST_LVL);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Thermometer code: bit i set iff i is below the given level.
    function automatic logic [NUM_LVL-1:0] thermo(input logic [LW-1:0] lvl);
        logic [NUM_LVL-1:0] t;
        t = {NUM_LVL{1'b0}};
        for (int i = 0; i < NUM_LVL; i++) begin
            t[i] = (i < int'(lvl)) ? 1'b1 : 1'b0;
        end
        return t;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      lvl_q, lvl_d;
    logic [NUM_LVL-1:0] led_q, led_d;
    logic               chg_q, chg_d;
    logic               long_q, long_d;

    // Next-state logic: press timing, level stepping and lockout sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        chg_d   = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A spurious release pulse here is ignored; only a low level starts a press.
                if (!pb_lvl) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESSED: begin
                if (released) begin
                    lvl_d   = (lvl_q == TOP_LVL) ? ZERO_LVL : (lvl_q + LW'(1));
                    chg_d   = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_LOCKOUT;
                end else if (pb_lvl) begin
                    // Level went high without a release pulse: treat as a glitch.
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    lvl_d   = ZERO_LVL;
                    long_d  = 1'b1;
                    chg_d   = (lvl_q != ZERO_LVL) ? 1'b1 : 1'b0;
                    state_d = ST_LONG;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_LONG: begin
                // Either way out restarts the counter so the lockout is timed in full.
                if (released || pb_lvl) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_LOCKOUT;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
        led_d = thermo(lvl_d);
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            lvl_q   <= INIT_LVL;
            led_q   <= thermo(INIT_LVL);
            chg_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            led_q   <= led_d;
            chg_q   <= chg_d;
            long_q  <= long_d;
        end
    end

    assign assist_lvl = lvl_q;
    assign led        = led_q;
    assign lvl_chg    = chg_q;
    assign long_press = long_q;

endmodule

// File: tb/tb_assist_level_sel.sv
// Directed testbench for assist_level_sel with short timing parameters.
// Each check compares {assist_lvl, led, lvl_chg, long_press} against a
// hand-computed vector one time unit after the clock edge.
module tb_assist_level_sel;

    logic       clk;
    logic       rst;
    logic       pb_lvl;
    logic       released;
    logic [1:0] assist_lvl;
    logic [3:0] led;
    logic       lvl_chg;
    logic       long_press;
    logic [7:0] obs;
    int         n_cmp;
    int         n_err;

    assist_level_sel #(
        .LONG_CYC   (8),
        .LOCKOUT_CYC(4),
        .NUM_LVL    (4),
        .RST_LVL    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_lvl    (pb_lvl),
        .released  (released),
        .assist_lvl(assist_lvl),
        .led       (led),
        .lvl_chg   (lvl_chg),
        .long_press(long_press)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    assign obs = {assist_lvl, led, lvl_chg, long_press};

    // Apply one input vector across one rising edge, then settle.
    task automatic cyc(input logic p, input logic r);
        pb_lvl   = p;
        released = r;
        @(posedge clk);
        #1;
    endtask

    // Released button for n cycles.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if (obs !== {2'd1, 4'b0001, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_values: got %b expected %b", obs, {2'd1, 4'b0001, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd2, 4'b0011, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL reset_pre_press: got %b expected %b", obs, {2'd2, 4'b0011, 1'b1, 1'b0});
        end
        idle(4);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        n_cmp++;
        if (obs !== {2'd2, 4'b0011, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_mid_press: got %b expected %b", obs, {2'd2, 4'b0011, 1'b0, 1'b0});
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== {2'd1, 4'b0001, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_async: got %b expected %b", obs, {2'd1, 4'b0001, 1'b0, 1'b0});
        end
        pb_lvl = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        n_cmp++;
        if (obs !== {2'd1, 4'b0001, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_fresh_press: got %b expected %b", obs, {2'd1, 4'b0001, 1'b0, 1'b0});
        end
    endtask

    task automatic test_short;
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd2, 4'b0011, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL short_step: got %b expected %b", obs, {2'd2, 4'b0011, 1'b1, 1'b0});
        end
        cyc(1'b1, 1'b0);
        n_cmp++;
        if (obs !== {2'd2, 4'b0011, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL short_pulse_end: got %b expected %b", obs, {2'd2, 4'b0011, 1'b0, 1'b0});
        end
        idle(3);
    endtask

    task automatic test_wrap;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd3, 4'b0111, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL wrap_to_top: got %b expected %b", obs, {2'd3, 4'b0111, 1'b1, 1'b0});
        end
        idle(4);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd0, 4'b0000, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL wrap_to_zero: got %b expected %b", obs, {2'd0, 4'b0000, 1'b1, 1'b0});
        end
        cyc(1'b1, 1'b0);
        n_cmp++;
        if (obs !== {2'd0, 4'b0000, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL wrap_pulse_end: got %b expected %b", obs, {2'd0, 4'b0000, 1'b0, 1'b0});
        end
        idle(3);
    endtask

    task automatic test_long;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        idle(4);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd2, 4'b0011, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL long_setup: got %b expected %b", obs, {2'd2, 4'b0011, 1'b1, 1'b0});
        end
        idle(4);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b0);
            if (i == 7) begin
                n_cmp++;
                if (obs !== {2'd2, 4'b0011, 1'b0, 1'b0}) begin
                    n_err++; $display("FAIL long_before: got %b expected %b", obs, {2'd2, 4'b0011, 1'b0, 1'b0});
                end
            end
            if (i == 8) begin
                n_cmp++;
                if (obs !== {2'd0, 4'b0000, 1'b1, 1'b1}) begin
                    n_err++; $display("FAIL long_detect: got %b expected %b", obs, {2'd0, 4'b0000, 1'b1, 1'b1});
                end
            end
            if (i == 9 || i == 20) begin
                n_cmp++;
                if (obs !== {2'd0, 4'b0000, 1'b0, 1'b0}) begin
                    n_err++; $display("FAIL long_held cycle %0d: got %b expected %b", i, obs, {2'd0, 4'b0000, 1'b0, 1'b0});
                end
            end
        end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd0, 4'b0000, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL long_release: got %b expected %b", obs, {2'd0, 4'b0000, 1'b0, 1'b0});
        end
        idle(4);
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0);
        n_cmp++;
        if (obs !== {2'd0, 4'b0000, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL long_at_zero: got %b expected %b", obs, {2'd0, 4'b0000, 1'b0, 1'b1});
        end
        cyc(1'b0, 1'b0);
        n_cmp++;
        if (obs !== {2'd0, 4'b0000, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL long_zero_end: got %b expected %b", obs, {2'd0, 4'b0000, 1'b0, 1'b0});
        end
        cyc(1'b1, 1'b1);
        idle(4);
    endtask

    task automatic test_lockout;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        idle(4);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd2, 4'b0011, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL lockout_first: got %b expected %b", obs, {2'd2, 4'b0011, 1'b1, 1'b0});
        end
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd2, 4'b0011, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL lockout_ignored: got %b expected %b", obs, {2'd2, 4'b0011, 1'b0, 1'b0});
        end
        idle(2);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd3, 4'b0111, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL lockout_after: got %b expected %b", obs, {2'd3, 4'b0111, 1'b1, 1'b0});
        end
        idle(4);
    endtask

    task automatic test_glitch;
        cyc(1'b0, 1'b0);
        n_cmp++;
        if (obs !== {2'd3, 4'b0111, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL glitch_press: got %b expected %b", obs, {2'd3, 4'b0111, 1'b0, 1'b0});
        end
        cyc(1'b1, 1'b0);
        n_cmp++;
        if (obs !== {2'd3, 4'b0111, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL glitch_high: got %b expected %b", obs, {2'd3, 4'b0111, 1'b0, 1'b0});
        end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd3, 4'b0111, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL spurious_release: got %b expected %b", obs, {2'd3, 4'b0111, 1'b0, 1'b0});
        end
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (obs !== {2'd0, 4'b0000, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL glitch_recover: got %b expected %b", obs, {2'd0, 4'b0000, 1'b1, 1'b0});
        end
        idle(4);
    endtask

    // Scenario sequence.
    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        pb_lvl   = 1'b1;
        released = 1'b0;
        n_cmp    = 0;
        n_err    = 0;
        test_reset();
        test_short();
        test_wrap();
        test_long();
        test_lockout();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
